rr_decode_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4-way decoded resource (bus, memory bank, or similar) among 4 requesters.
- Outputs the winner both as a 2-bit index and as an active-low one-hot select, so it drives decoded chip-selects directly.
- Adds hold-timeout enforcement and a one-cycle turnaround gap between owners.
- Sits between requesting masters and the shared resource's select lines.

---
 rtl/rr_decode_arbiter_if.sv | 28 ++
 rtl/rr_decode_arbiter.sv | 111 +++++++++++
 tb/tb_rr_decode_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesting masters and the round-robin
// decode arbiter. The arbiter drives the active-low chip-selects.
interface rr_decode_arbiter_if;
  logic       en_n;
  logic [3:0] req;
  logic [3:0] grant_n;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output en_n,
    output req,
    input  grant_n,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  en_n,
    input  req,
    output grant_n,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Four-way round-robin arbiter with one-hot active-low selects, a hold
// timeout and a mandatory one-cycle turnaround gap between owners.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_decode_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       grant_n_q;
  logic [1:0]       grant_idx_q;
  logic             grant_valid_q;
  logic             timeout_q;

  logic             win_valid_d;
  logic [1:0]       win_idx_d;
  logic [1:0]       cand_idx_d;
  logic             owner_req_d;
  logic             hold_hit_d;
  logic [CNT_W-1:0] cnt_inc_d;

  // Rotating-priority search: walk from ptr+3 down to ptr so ptr wins last.
  always_comb begin
    win_valid_d = 1'b0;
    win_idx_d   = 2'd0;
    cand_idx_d  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand_idx_d = ptr_q + 2'(i);
      if (bus.req[cand_idx_d]) begin
        win_valid_d = 1'b1;
        win_idx_d   = cand_idx_d;
      end else begin
        win_valid_d = win_valid_d;
      end
    end
  end

  assign owner_req_d = bus.req[grant_idx_q];
  assign hold_hit_d  = HOLD_EN && (cnt_q == HOLD_LAST);
  assign cnt_inc_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Arbiter FSM with registered grant/timeout outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      cnt_q         <= {CNT_W{1'b0}};
      grant_n_q     <= 4'b1111;
      grant_idx_q   <= 2'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, GAP: begin
          timeout_q <= 1'b0;
          if (!bus.en_n && win_valid_d) begin
            state_q       <= OWN;
            grant_n_q     <= ~(4'b0001 << win_idx_d);
            grant_idx_q   <= win_idx_d;
            grant_valid_q <= 1'b1;
            cnt_q         <= {CNT_W{1'b0}};
          end else begin
            state_q <= IDLE;
          end
        end
        OWN: begin
          if (!owner_req_d || hold_hit_d) begin
            state_q       <= GAP;
            ptr_q         <= grant_idx_q + 2'd1;
            grant_n_q     <= 4'b1111;
            grant_idx_q   <= 2'd0;
            grant_valid_q <= 1'b0;
            // Still requesting here means the hold limit forced the release.
            timeout_q     <= owner_req_d;
          end else begin
            cnt_q     <= cnt_inc_d;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          grant_n_q     <= 4'b1111;
          grant_idx_q   <= 2'd0;
          grant_valid_q <= 1'b0;
          timeout_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_n     = grant_n_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter (MAX_HOLD=4).
module tb_rr_decode_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] obs;

  rr_decode_arbiter_if bus ();

  rr_decode_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {grant_n, grant_idx, grant_valid, timeout}
  assign obs = {bus.grant_n, bus.grant_idx, bus.grant_valid, bus.timeout};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en_n = 1'b0;
    bus.req  = 4'b0000;
    tick();
    checks++;
    if (obs !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got %b want %b", obs, {4'b1111, 2'd0, 1'b0, 1'b0});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle: got %b want %b", obs, {4'b1111, 2'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_single_grant();
    test_reset();
    bus.req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs !== {4'b1011, 2'd2, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL single_own[%0d]: got %b want %b", k, obs, {4'b1011, 2'd2, 1'b1, 1'b0});
      end
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if (obs !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_gap: got %b want %b", obs, {4'b1111, 2'd0, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if (obs !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_idle: got %b want %b", obs, {4'b1111, 2'd0, 1'b0, 1'b0});
    end
    // ptr is now 3: requesters 0 and 3 contend, 3 must win
    bus.req = 4'b1001;
    tick();
    checks++;
    if (obs !== {4'b0111, 2'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_ptr3: got %b want %b", obs, {4'b0111, 2'd3, 1'b1, 1'b0});
    end
  endtask

  task automatic test_rotation_timeout();
    logic [1:0] oi;
    logic [3:0] exp_gn;
    test_reset();
    bus.req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      oi = o[1:0];
      exp_gn = ~(4'b0001 << oi);
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++;
        if (obs !== {exp_gn, oi, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL rot_own[%0d][%0d]: got %b want %b", o, k, obs, {exp_gn, oi, 1'b1, 1'b0});
        end
      end
      tick();
      checks++;
      if (obs !== {4'b1111, 2'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL rot_gap[%0d]: got %b want %b", o, obs, {4'b1111, 2'd0, 1'b0, 1'b1});
      end
    end
  endtask

  task automatic test_sole_requester();
    test_reset();
    bus.req = 4'b0010;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++;
        if (obs !== {4'b1101, 2'd1, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL sole_own[%0d][%0d]: got %b want %b", r, k, obs, {4'b1101, 2'd1, 1'b1, 1'b0});
        end
      end
      tick();
      checks++;
      if (obs !== {4'b1111, 2'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL sole_gap[%0d]: got %b want %b", r, obs, {4'b1111, 2'd0, 1'b0, 1'b1});
      end
    end
  endtask

  task automatic test_back_to_back();
    test_reset();
    bus.req = 4'b0001;
    tick();
    checks++;
    if (obs !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_own0: got %b want %b", obs, {4'b1110, 2'd0, 1'b1, 1'b0});
    end
    bus.req = 4'b1000;
    tick();
    checks++;
    if (obs !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_gap: got %b want %b", obs, {4'b1111, 2'd0, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if (obs !== {4'b0111, 2'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_own3: got %b want %b", obs, {4'b0111, 2'd3, 1'b1, 1'b0});
    end
    // other lines joining mid-grant must not disturb owner 3
    bus.req = 4'b1111;
    tick();
    checks++;
    if (obs !== {4'b0111, 2'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_ignore: got %b want %b", obs, {4'b0111, 2'd3, 1'b1, 1'b0});
    end
  endtask

  task automatic test_enable();
    test_reset();
    bus.req = 4'b0100;
    tick();
    checks++;
    if (obs !== {4'b1011, 2'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL en_own2: got %b want %b", obs, {4'b1011, 2'd2, 1'b1, 1'b0});
    end
    bus.en_n = 1'b1;
    tick();
    checks++;
    if (obs !== {4'b1011, 2'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL en_keep: got %b want %b", obs, {4'b1011, 2'd2, 1'b1, 1'b0});
    end
    bus.req = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL en_blocked[%0d]: got %b want %b", k, obs, {4'b1111, 2'd0, 1'b0, 1'b0});
      end
    end
    bus.en_n = 1'b0;
    tick();
    checks++;
    if (obs !== {4'b0111, 2'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL en_resume: got %b want %b", obs, {4'b0111, 2'd3, 1'b1, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    test_reset();
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b1111;
    tick();
    checks++;
    if (obs !== {4'b1011, 2'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL arst_pre: got %b want %b", obs, {4'b1011, 2'd2, 1'b1, 1'b0});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL arst_drop: got %b want %b", obs, {4'b1111, 2'd0, 1'b0, 1'b0});
    end
    #1 rst = 1'b0;
    tick();
    checks++;
    if (obs !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL arst_regrant: got %b want %b", obs, {4'b1110, 2'd0, 1'b1, 1'b0});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.en_n = 1'b1;
    bus.req = 4'b0000;
    test_reset();
    test_single_grant();
    test_rotation_timeout();
    test_sole_requester();
    test_back_to_back();
    test_enable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
